i2c_master_ctrl: RTL

- Single-master I2C controller that sequences the shared SDA/SCL bus for the team's I2C slave and any other slaves on it.
- Accepts one command per transaction: 7-bit address, R/W, one data byte, and a stop/no-stop flag.
- Generates START, repeated START, address, data, ACK/NACK and STOP with open-drain style outputs, and supports slave clock stretching.
- Sits between an on-chip requester (CPU or sequencer) and the board-level SDA/SCL pads.

---
 rtl/i2c_master_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C controller, one byte per command, open-drain outputs
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_stop,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP, HOLD, RSTART
  } state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] ab_q, ab_d, wd_q, wd_d, sh_q, sh_d, rsp_rdata_q, rsp_rdata_d;
  logic stop_q, stop_d, nack_q, nack_d, rsp_valid_q, rsp_valid_d, rsp_nack_q, rsp_nack_d;
  logic slot, frz, tick, last, smp, accept, done;
  assign busy      = state_q != IDLE;
  assign cmd_ready = state_q == IDLE || state_q == HOLD;
  assign accept    = cmd_valid && cmd_ready;
  assign slot      = state_q inside {ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK};
  // a slave holding SCL low while we have released it stalls the bit clock
  assign frz       = !scl_in && ((slot && ph_q == 2'd2) || (state_q == RSTART && ph_q == 2'd1));
  assign tick      = busy && !frz && div_q == DMAX;
  assign last      = tick && ph_q == 2'd3;
  assign smp       = tick && ph_q == 2'd2;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_nack  = rsp_nack_q;
  assign scl_oe    = slot ? !ph_q[1] : state_q == STOP ? ph_q == 2'd0
                   : state_q == HOLD || (state_q == RSTART && ph_q == 2'd0);
  assign sda_oe    = state_q == START || (state_q == ADDR && !ab_q[~bit_q])
                   || (state_q == WDATA && !wd_q[~bit_q]) || (state_q == STOP && !ph_q[1]);
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:      if (accept) state_d = START;
      START:     if (tick && ph_q[0]) state_d = ADDR;
      ADDR:      if (last && &bit_q) state_d = ADDR_ACK;
      ADDR_ACK:  if (last) state_d = nack_q ? STOP : ab_q[0] ? RDATA : WDATA;
      WDATA:     if (last && &bit_q) state_d = WDATA_ACK;
      RDATA:     if (last && &bit_q) state_d = RDATA_ACK;
      WDATA_ACK, RDATA_ACK: if (last) begin
        state_d = (stop_q || nack_q) ? STOP : HOLD;
        done    = !(stop_q || nack_q);
      end
      STOP:      if (tick && ph_q == 2'd3) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      HOLD:      if (accept) state_d = RSTART;
      RSTART:    if (tick && ph_q[0]) state_d = START;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    div_d       = accept ? '0 : (busy && !frz) ? (div_q == DMAX ? '0 : div_q + 1'b1) : div_q;
    ph_d        = state_d != state_q ? 2'd0 : tick ? ph_q + 2'd1 : ph_q;
    bit_d       = state_d != state_q ? 3'd0 : last ? bit_q + 3'd1 : bit_q;
    ab_d        = accept ? {cmd_addr, cmd_rw} : ab_q;
    wd_d        = accept ? cmd_wdata : wd_q;
    stop_d      = accept ? cmd_stop : stop_q;
    nack_d      = accept ? 1'b0 : (smp && (state_q == ADDR_ACK || state_q == WDATA_ACK)) ? nack_q | sda_in : nack_q;
    sh_d        = (smp && state_q == RDATA) ? {sh_q[6:0], sda_in} : sh_q;
    rsp_valid_d = done;
    rsp_nack_d  = done ? nack_q : rsp_nack_q;
    rsp_rdata_d = (done && ab_q[0] && !nack_q) ? sh_q : rsp_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      ph_q        <= 2'd0;
      bit_q       <= 3'd0;
      ab_q        <= 8'd0;
      wd_q        <= 8'd0;
      sh_q        <= 8'd0;
      stop_q      <= 1'b0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      ab_q        <= ab_d;
      wd_q        <= wd_d;
      sh_q        <= sh_d;
      stop_q      <= stop_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule
